// File: rtl/stack_ctrl_pkg.sv
// Shared types and defaults for the return-address stack sequencer.
// Holds the FSM encoding, default widths/vectors and the decoded-event bundle.
package stack_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        POP_WAIT = 2'd1,
        LOAD     = 2'd2
    } state_t;

    localparam int AW_DEF    = 10;
    localparam int DEPTH_DEF = 16;
    localparam int DEPTH_W   = 5;

    localparam logic [AW_DEF-1:0] IRQ_VEC_DEF  = 10'h3F0;
    localparam logic [AW_DEF-1:0] TRAP_VEC_DEF = 10'h3F8;

    // One-hot-ish view of what the IDLE state decided to do this cycle.
    typedef struct packed {
        logic irq_entry;
        logic call_go;
        logic pop_go;
        logic ovf;
        logic udf;
        logic reti_udf;
    } evt_t;

endpackage

// File: rtl/stack_depth_cnt.sv
// Saturating occupancy counter for the return-address stack, 1-cycle update.
// inc and dec in the same cycle cancel; full/empty are decoded from the count.
module stack_depth_cnt #(
    parameter int DEPTH = 16,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty
);

    assign full  = (count == W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + W'(1);
        end else if (dec && !inc && !empty) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/call_stack_ctrl.sv
// CALL/RET/RETI/IRQ sequencer for the return-address stack; CALL/IRQ redirect in 1 cycle, RET in 2 with stall.
// Optional STACK_TRAP_EN: overflow/underflow redirect to TRAP_VEC and mask interrupts.
module call_stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            DEPTH    = DEPTH_DEF,
    parameter logic [AW-1:0] IRQ_VEC  = IRQ_VEC_DEF,
    parameter logic [AW-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               call,
    input  logic               ret,
    input  logic               reti,
    input  logic               irq,
    input  logic [AW-1:0]      pc_cur,
    input  logic [AW-1:0]      call_target,
    input  logic [AW-1:0]      stack_outpop,
    output logic               stack_push,
    output logic               stack_pop,
    output logic [AW-1:0]      stack_inpush,
    output logic               stack_rst,
    output logic               pc_load,
    output logic [AW-1:0]      pc_next,
    output logic               stall,
    output logic               irq_ack,
    output logic               int_en,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow
);

`ifdef STACK_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t state;
    state_t state_nxt;
    evt_t   evt;
    logic   full;
    logic   empty;
    logic   pop_reti;
    logic   take_irq;
    logic   want_ret;

    assign stack_rst = reset;
    assign take_irq  = irq & int_en;
    assign want_ret  = ret | reti;

    stack_depth_cnt #(
        .DEPTH (DEPTH),
        .W     (DEPTH_W)
    ) u_depth_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stack_push),
        .dec   (stack_pop),
        .count (depth),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (evt.pop_go) state_nxt = POP_WAIT;
            POP_WAIT: state_nxt = LOAD;
            LOAD:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        evt          = '0;
        stack_push   = 1'b0;
        stack_pop    = 1'b0;
        stall        = 1'b0;
        stack_inpush = pc_cur;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (take_irq) begin
                        // The stack returns data+1, so push pc_cur-1 to resume at pc_cur.
                        stack_inpush = pc_cur - AW'(1);
                        if (full) begin
                            evt.ovf = 1'b1;
                        end else begin
                            evt.irq_entry = 1'b1;
                            stack_push    = 1'b1;
                        end
                    end else if (call) begin
                        if (full) begin
                            evt.ovf = 1'b1;
                        end else begin
                            evt.call_go = 1'b1;
                            stack_push  = 1'b1;
                        end
                    end else if (want_ret) begin
                        if (empty) begin
                            evt.udf      = 1'b1;
                            evt.reti_udf = reti;
                        end else begin
                            evt.pop_go = 1'b1;
                            stack_pop  = 1'b1;
                            stall      = 1'b1;
                        end
                    end
                end
            end
            POP_WAIT: stall = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_load   <= 1'b0;
            pc_next   <= '0;
            irq_ack   <= 1'b0;
            int_en    <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            pop_reti  <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            irq_ack <= 1'b0;
            if (evt.irq_entry) begin
                pc_load <= 1'b1;
                pc_next <= IRQ_VEC;
                irq_ack <= 1'b1;
                int_en  <= 1'b0;
            end else if (evt.call_go) begin
                pc_load <= 1'b1;
                pc_next <= call_target;
            end else if (state == POP_WAIT) begin
                pc_load <= 1'b1;
                pc_next <= stack_outpop;
                if (pop_reti) int_en <= 1'b1;
            end
            if (evt.pop_go) pop_reti <= reti;
            if (evt.ovf) overflow <= 1'b1;
            if (evt.udf) begin
                underflow <= 1'b1;
                if (evt.reti_udf) int_en <= 1'b1;
            end
            // Trap redirect overrides the RETI re-enable above.
            if (TRAP_EN && (evt.ovf || evt.udf)) begin
                pc_load <= 1'b1;
                pc_next <= TRAP_VEC;
                int_en  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
- Sequencer for the 10-bit × 16-entry return-address stack: turns decoded CALL/RET/RETI and an external interrupt request into stack push/pop strobes and PC redirects.
- Tracks stack occupancy, blocks overflow/underflow, masks nested interrupts and stalls the fetch stage while pop data is in flight.
- Sits between the instruction decoder, the PC register and the stack instance.
- The stack stores the pushed value and returns it +1 on pop, so this block always pushes "return address − 1".

Parameters:
- AW, 10, address/PC width; must match the stack data width.
- DEPTH, 16, stack capacity in entries.
- IRQ_VEC, 10'h3F0, PC loaded on interrupt entry.
- TRAP_VEC, 10'h3F8, PC loaded on a stack error (only with STACK_TRAP_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- call  in  1  decoded CALL, valid for the instruction at pc_cur.
- ret  in  1  decoded RET.
- reti  in  1  decoded RETI (RET plus re-enable interrupts).
- irq  in  1  level interrupt request.
- pc_cur  in  AW  PC of the instruction currently in decode.
- call_target  in  AW  CALL destination.
- stack_outpop  in  AW  stack read data (already +1).
- stack_push  out  1  push strobe to the stack.
- stack_pop  out  1  pop strobe to the stack.
- stack_inpush  out  AW  push data.
- stack_rst  out  1  stack reset; equals reset.
- pc_load  out  1  registered; PC takes pc_next this cycle.
- pc_next  out  AW  registered redirect address.
- stall  out  1  hold fetch/decode; decoder keeps call/ret/reti stable.
- irq_ack  out  1  one-cycle pulse on interrupt entry.
- int_en  out  1  interrupt enable flag.
- depth  out  5  entries in use, 0..DEPTH.
- overflow  out  1  sticky error flag.
- underflow  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, depth=0, int_en=1.
  - overflow=0, underflow=0, pc_load=0, pc_next=0, irq_ack=0.
  - stack_push=0 and stack_pop=0 are forced; stack_rst=1.
  - Reset mid-operation (including in POP_WAIT) abandons the operation; no strobe is issued that cycle.
- stack_push, stack_pop, stack_inpush and stall are combinational from state and inputs. pc_load, pc_next and irq_ack are registered.
- FSM states: IDLE, POP_WAIT, LOAD.
- IDLE priority: irq&int_en > call > ret/reti. call, ret and reti are mutually exclusive; if more than one is asserted, underflow logic is unaffected and call wins.
- IRQ (IDLE, irq=1, int_en=1, depth<DEPTH):
  - stack_push=1, stack_inpush=pc_cur−1 (mod 2^AW), so the return lands on pc_cur.
  - Next cycle: pc_load=1, pc_next=IRQ_VEC, irq_ack=1, int_en=0, depth+1.
  - call/ret in that cycle are discarded; the instruction re-executes after return.
- CALL (depth<DEPTH):
  - stack_push=1, stack_inpush=pc_cur.
  - Next cycle: pc_load=1, pc_next=call_target, depth+1.
  - Latency 1, no stall.
- RET/RETI (depth>0):
  - Cycle N: stack_pop=1, stall=1, go to POP_WAIT.
  - N+1: stall=1; capture stack_outpop; go to LOAD.
  - N+2: pc_load=1, pc_next=captured value, stall=0; RETI also sets int_en=1 here; depth−1 at end of N.
  - POP_WAIT and LOAD ignore all inputs; irq is held off until IDLE.
- Overflow (call, or a taken irq, with depth==DEPTH):
  - No push; overflow set; depth unchanged.
  - The call is treated as NOP (no pc_load). An irq stays pending, but irq_ack is not issued.
- Underflow (ret/reti with depth==0):
  - No pop; underflow set; NOP; RETI still sets int_en.
- Wrap-around: pc_cur=0 on IRQ pushes 2^AW−1; the stack's +1 wraps back to 0.
- Error flags clear only on reset.

Optional Feature:
- Macro name: STACK_TRAP_EN.
- Defined: an overflow/underflow event additionally produces pc_load=1 with pc_next=TRAP_VEC on the next cycle, and int_en=0.
- Undefined: error events are silent NOPs; only the sticky flags are set.

Decomposition:
- Package stack_ctrl_pkg:
  - FSM state encoding (IDLE=2'd0, POP_WAIT=2'd1, LOAD=2'd2).
  - Default AW/DEPTH.
  - IRQ_VEC/TRAP_VEC defaults.
- Sub-module stack_depth_cnt:
  - Saturating up/down occupancy counter with inc/dec inputs.
  - full/empty outputs, synchronous reset.
  - Instantiated once.

Test Plan:
- Reset, then call at pc_cur=10'd5, call_target=10'd100 → push of 5 in the same cycle; pc_load with pc_next=100 next cycle; depth=1.
- Following ret → stall for 2 cycles; pc_load with pc_next=6 in cycle N+2; depth=0.
- irq at pc_cur=10'd0 → stack_inpush=10'h3FF, irq_ack, pc_next=10'h3F0, int_en=0; second irq ignored until reti, which returns to 0 and sets int_en=1.
- 16 calls then a 17th → 17th produces no push, overflow=1, depth=16; 16 rets return targets in LIFO order.
- ret at depth=0 → no pop, underflow=1; with STACK_TRAP_EN, pc_next=10'h3F8.
- Assert reset during POP_WAIT → no pc_load; all outputs at reset values next cycle; depth=0.
